// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time tester sequencer.
// Holds the state encodings, the CounterFlag codes driven to the
// millisecond counter, the timeout ceiling and the LFSR feedback helper.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_WAIT    = 3'b001,
        ST_RUN     = 3'b010,
        ST_HOLD    = 3'b011,
        ST_DONE    = 3'b100,
        ST_FOUL    = 3'b101,
        ST_TIMEOUT = 3'b110,
        ST_UNUSED  = 3'b111
    } state_t;

    localparam logic [1:0] CF_CLEAR = 2'b00;
    localparam logic [1:0] CF_HOLD  = 2'b01;
    localparam logic [1:0] CF_RUN   = 2'b10;

    localparam logic [9:0] MAX_MS = 10'd999;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One shift of the 16-bit Fibonacci LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // CounterFlag requested by each state.
    function automatic logic [1:0] cf_for_state(input state_t s);
        logic [1:0] cf;
        case (s)
            ST_RUN:     cf = CF_RUN;
            ST_HOLD:    cf = CF_HOLD;
            ST_DONE:    cf = CF_HOLD;
            ST_TIMEOUT: cf = CF_HOLD;
            default:    cf = CF_CLEAR;
        endcase
        return cf;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: a prescaler counting 0..CLK_PER_MS-1.
// tick_o is high for exactly one clock while the prescaler sits on its
// last count, i.e. once per CLK_PER_MS clocks.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   clr_i   synchronous clear; prescaler restarts from 0 next cycle
//   tick_o  registered one-cycle tick
module ms_tick_gen #(
    parameter int unsigned CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;
    logic             tick_d;

    // Next prescaler value: clear wins, otherwise wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick is precomputed from the next count so it is high while cnt_q==LAST.
    assign tick_d = (cnt_d == LAST) && !clr_i;

    // Prescaler and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Game sequencer for the reaction-time tester.
// Generates a pseudo-random arming delay, drives the counter's CounterFlag,
// lights the GO lamp, detects fouls and timeouts, and latches the last
// result and the session best for the display logic.
// Ports:
//   clk_50M       system clock
//   rst_n         asynchronous active-low reset
//   start_p       one-cycle start button pulse
//   react_p       one-cycle reaction button pulse
//   count_value   millisecond counter value
//   counter_flag  CounterFlag to the counter (00 clear, 01 hold, 10 run)
//   go_led        reaction lamp
//   foul          early press indicator
//   timeout       ceiling reached indicator
//   result        last measured time in ms
//   result_valid  one-cycle pulse when result updates
//   best_time     lowest valid result since reset
//   best_valid    best_time is meaningful
//   state_o       current state code
module reaction_timer_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned CLK_PER_MS   = 50000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 10,
    parameter logic [9:0]  MAX_MS       = reaction_pkg::MAX_MS,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       start_p,
    input  logic       react_p,
    input  logic [9:0] count_value,
    output logic [1:0] counter_flag,
    output logic       go_led,
    output logic       foul,
    output logic       timeout,
    output logic [9:0] result,
    output logic       result_valid,
    output logic [9:0] best_time,
    output logic       best_valid,
    output logic [2:0] state_o
);

    localparam int unsigned DELAY_W = 11;

    state_t             state_q;
    state_t             state_d;
    logic [15:0]        lfsr_q;
    logic [DELAY_W-1:0] delay_q;
    logic [DELAY_W-1:0] delay_d;
    logic [DELAY_W-1:0] new_delay_s;
    logic               hold_cnt_q;
    logic               hold_cnt_d;
    logic [9:0]         result_q;
    logic [9:0]         result_d;
    logic               valid_q;
    logic               valid_d;
    logic [9:0]         best_q;
    logic               best_valid_q;
    logic [1:0]         flag_q;
    logic               go_q;
    logic               foul_q;
    logic               timeout_q;
    logic               tick_s;
    logic               clr_s;

    // Restart the prescaler on every entry to WAIT so the delay is measured
    // from a clean millisecond boundary.
    assign clr_s = (state_d == ST_WAIT) && (state_q != ST_WAIT);

    ms_tick_gen #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_tick (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .clr_i (clr_s),
        .tick_o(tick_s)
    );

    // Free-running LFSR; sampled only when a new delay is armed.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign new_delay_s = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q[RAND_BITS-1:0]);

    // Next-state, delay countdown and result capture.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        hold_cnt_d = 1'b0;
        result_d   = result_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_FOUL, ST_TIMEOUT: begin
                if (start_p) begin
                    state_d = ST_WAIT;
                    delay_d = new_delay_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                // An early press beats a delay expiring on the same cycle.
                if (react_p) begin
                    state_d = ST_FOUL;
                end else if (tick_s) begin
                    if (delay_q == 11'd1) begin
                        state_d = ST_RUN;
                        delay_d = 11'd0;
                    end else begin
                        delay_d = delay_q - 11'd1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RUN: begin
                // A press on the ceiling cycle still counts as a valid reaction.
                if (react_p) begin
                    state_d = ST_HOLD;
                end else if (count_value == MAX_MS) begin
                    state_d  = ST_TIMEOUT;
                    result_d = MAX_MS;
                    valid_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                // Two cycles let the counter settle under the hold flag.
                if (hold_cnt_q) begin
                    state_d  = ST_DONE;
                    result_d = count_value;
                    valid_d  = 1'b1;
                end else begin
                    hold_cnt_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, delay, hold counter and result registers.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            delay_q    <= '0;
            hold_cnt_q <= 1'b0;
            result_q   <= 10'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            hold_cnt_q <= hold_cnt_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

    // Session best: updated on the DONE entry cycle (valid_q marks entry);
    // timeouts never land in DONE so they never update it.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            best_q       <= 10'd0;
            best_valid_q <= 1'b0;
        end else if ((state_q == ST_DONE) && valid_q) begin
            if (!best_valid_q || (result_q < best_q)) begin
                best_q <= result_q;
            end
            best_valid_q <= 1'b1;
        end
    end

    // State-decoded outputs, registered one cycle behind the state.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= CF_CLEAR;
            go_q      <= 1'b0;
            foul_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            flag_q    <= cf_for_state(state_q);
            go_q      <= (state_q == ST_RUN);
            foul_q    <= (state_q == ST_FOUL);
            timeout_q <= (state_q == ST_TIMEOUT);
        end
    end

    assign counter_flag = flag_q;
    assign go_led       = go_q;
    assign foul         = foul_q;
    assign timeout      = timeout_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign best_time    = best_q;
    assign best_valid   = best_valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl with a behavioural ms counter,
// an independent LFSR model for the arming delay, and a result scoreboard.
module tb_reaction_timer_ctrl;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_p = 1'b0;
    logic       react_p = 1'b0;
    logic [9:0] count_value;
    logic [1:0] counter_flag;
    logic       go_led;
    logic       foul;
    logic       timeout;
    logic [9:0] result;
    logic       result_valid;
    logic [9:0] best_time;
    logic       best_valid;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    logic [15:0] lfsr_m;
    logic [9:0]  bc;
    logic [1:0]  bdiv;
    logic        jump_req = 1'b0;

    reaction_timer_ctrl #(
        .CLK_PER_MS  (4),
        .MIN_DELAY_MS(1000),
        .RAND_BITS   (10),
        .MAX_MS      (10'd999),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .start_p     (start_p),
        .react_p     (react_p),
        .count_value (count_value),
        .counter_flag(counter_flag),
        .go_led      (go_led),
        .foul        (foul),
        .timeout     (timeout),
        .result      (result),
        .result_valid(result_valid),
        .best_time   (best_time),
        .best_valid  (best_valid),
        .state_o     (state_o)
    );

    always #5 clk_50M = ~clk_50M;

    // Reference LFSR: x^16+x^14+x^13+x^11, shifting left, seed ACE1.
    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    // Behavioural millisecond counter obeying CounterFlag (4 clocks per ms).
    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            bc   <= 10'd0;
            bdiv <= 2'd0;
        end else if (jump_req) begin
            bc   <= 10'd990;
            bdiv <= 2'd0;
        end else if (counter_flag == 2'b00) begin
            bc   <= 10'd0;
            bdiv <= 2'd0;
        end else if (counter_flag == 2'b10) begin
            if (bdiv == 2'd3) begin
                bdiv <= 2'd0;
                if (bc < 10'd999) bc <= bc + 10'd1;
            end else begin
                bdiv <= bdiv + 2'd1;
            end
        end
    end
    assign count_value = bc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic start_and_arm(input string tag);
        int d;
        int cyc;
        d = 1000 + int'(lfsr_m[9:0]);
        start_p = 1'b1;
        @(negedge clk_50M);
        start_p = 1'b0;
        cyc = 0;
        check({tag, "_state_wait"}, 32'(state_o), 32'd1);
        while (!go_led && cyc < 10000) begin
            @(negedge clk_50M);
            cyc++;
            if (cyc == 2) begin
                check({tag, "_flag_clear"}, 32'(counter_flag), 32'd0);
                check({tag, "_foul_clear"}, 32'(foul), 32'd0);
                check({tag, "_timeout_clear"}, 32'(timeout), 32'd0);
            end
        end
        check({tag, "_go_latency"}, 32'(cyc), 32'(4 * d + 1));
        check({tag, "_flag_run"}, 32'(counter_flag), 32'd2);
    endtask

    task automatic wait_result(input string tag, input int limit);
        int n;
        int e;
        n = 0;
        while (!result_valid && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        check({tag, "_valid_seen"}, 32'(result_valid), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_result"}, 32'(result), 32'(e));
        @(negedge clk_50M);
        check({tag, "_valid_pulse"}, 32'(result_valid), 32'd0);
    endtask

    task automatic press_at(input string tag, input logic [9:0] v);
        int n;
        n = 0;
        while (count_value !== v && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
        check({tag, "_reach"}, 32'(count_value), 32'(v));
        exp_q.push_back(int'(v));
        react_p = 1'b1;
        @(negedge clk_50M);
        react_p = 1'b0;
        check({tag, "_state_hold"}, 32'(state_o), 32'd3);
        @(negedge clk_50M);
        check({tag, "_flag_hold"}, 32'(counter_flag), 32'd1);
        check({tag, "_go_off"}, 32'(go_led), 32'd0);
        wait_result(tag, 20);
    endtask

    initial begin
        repeat (3) @(negedge clk_50M);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_flag", 32'(counter_flag), 32'd0);
        check("rst_outs", 32'({go_led, foul, timeout, result_valid, best_valid}), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_best", 32'(best_time), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50M);
        check("idle_state", 32'(state_o), 32'd0);

        // Run 1: first result becomes the best.
        start_and_arm("run1");
        press_at("run1", 10'd237);
        check("run1_best", 32'(best_time), 32'd237);
        check("run1_best_valid", 32'(best_valid), 32'd1);
        react_p = 1'b1;
        @(negedge clk_50M);
        react_p = 1'b0;
        @(negedge clk_50M);
        check("done_react_state", 32'(state_o), 32'd4);
        check("done_react_result", 32'(result), 32'd237);

        // Run 2: slower result leaves the best alone.
        start_and_arm("run2");
        press_at("run2", 10'd412);
        check("run2_best", 32'(best_time), 32'd237);

        // Run 3: start_p in RUN ignored, faster result becomes best.
        start_and_arm("run3");
        repeat (3) @(negedge clk_50M);
        start_p = 1'b1;
        @(negedge clk_50M);
        start_p = 1'b0;
        @(negedge clk_50M);
        check("run_start_ignored", 32'(state_o), 32'd2);
        press_at("run3", 10'd150);
        check("run3_best", 32'(best_time), 32'd150);

        // Foul: press during WAIT.
        start_p = 1'b1;
        @(negedge clk_50M);
        start_p = 1'b0;
        repeat (4) @(negedge clk_50M);
        react_p = 1'b1;
        @(negedge clk_50M);
        react_p = 1'b0;
        check("foul_state", 32'(state_o), 32'd5);
        @(negedge clk_50M);
        check("foul_level", 32'(foul), 32'd1);
        check("foul_flag", 32'(counter_flag), 32'd0);
        check("foul_go", 32'(go_led), 32'd0);

        // Restart from FOUL, then let the counter reach the ceiling.
        start_and_arm("afterfoul");
        jump_req = 1'b1;
        @(negedge clk_50M);
        jump_req = 1'b0;
        exp_q.push_back(999);
        wait_result("tmo", 100);
        check("tmo_state", 32'(state_o), 32'd6);
        check("tmo_level", 32'(timeout), 32'd1);
        check("tmo_best", 32'(best_time), 32'd150);

        // Press on the exact ceiling cycle takes the HOLD path.
        start_and_arm("aftertmo");
        jump_req = 1'b1;
        @(negedge clk_50M);
        jump_req = 1'b0;
        press_at("r999", 10'd999);
        check("r999_state", 32'(state_o), 32'd4);
        check("r999_timeout", 32'(timeout), 32'd0);
        check("r999_best", 32'(best_time), 32'd150);

        // Asynchronous reset in the middle of RUN.
        start_and_arm("rstrun");
        repeat (8) @(negedge clk_50M);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state_o), 32'd0);
        check("mid_rst_flag", 32'(counter_flag), 32'd0);
        check("mid_rst_outs", 32'({go_led, foul, timeout, result_valid, best_valid}), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_best", 32'(best_time), 32'd0);
        @(negedge clk_50M);
        rst_n = 1'b1;
        @(negedge clk_50M);
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_flag", 32'(counter_flag), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
